// File: rtl/duty_meas_ctrl_pkg.sv
// Shared definitions for the duty-cycle measurement controller.
// Holds the FSM state encoding and the default counter width and period
// limits. The display path uses the same period limits.
package duty_meas_ctrl_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int T_MIN_DEF = 20;
  localparam int T_MAX_DEF = 500;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_HIGH = 3'd2,
    S_LOW  = 3'd3,
    S_DONE = 3'd4,
    S_HOLD = 3'd5
  } state_t;

endpackage

// File: rtl/duty_meas_ctrl_if.sv
// Control and result bundle of the duty-cycle measurement controller.
//   start, auto_en           : requests from the controlling side
//   tH, T                    : last good high time and period, in ticks
//   valid                    : one-cycle pulse when tH/T update
//   timeout, range_err, busy : status flags
// master = controlling side, slave = measurement controller.
interface duty_meas_ctrl_if
  import duty_meas_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             start;
  logic             auto_en;
  logic [CNT_W-1:0] tH;
  logic [CNT_W-1:0] T;
  logic             valid;
  logic             timeout;
  logic             range_err;
  logic             busy;

  modport master (
    output start, auto_en,
    input  tH, T, valid, timeout, range_err, busy
  );

  modport slave (
    input  start, auto_en,
    output tH, T, valid, timeout, range_err, busy
  );
endinterface

// File: rtl/duty_meas_ctrl_edge_sync.sv
// edge_sync: brings an asynchronous level into the clock domain and
// reports its edges.
//   clk   : clock
//   rst_n : synchronous reset, active-low
//   d     : asynchronous input level
//   rise  : one-cycle pulse on a 0->1 transition of the synchronised level
//   fall  : one-cycle pulse on a 1->0 transition of the synchronised level
// Both edges pass through the same three flops, so the distance between
// a rise and the following fall equals the pin pulse width in ticks.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/duty_meas_ctrl.sv
// duty_meas_ctrl: runs one timed duty-cycle measurement of ft per cycle:
// arm, count high time, count low time, publish, hold, optionally re-arm.
//   inclk0 : clock (100 MHz PLL output, 10 ns per tick)
//   rst_n  : synchronous reset, active-low
//   ft     : measured signal, asynchronous
//   bus    : start/auto_en requests in; tH, T, valid, timeout,
//            range_err, busy out
module duty_meas_ctrl
  import duty_meas_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int T_MIN    = T_MIN_DEF,
  parameter int T_MAX    = T_MAX_DEF,
  parameter int TMO_MAX  = 65535,
  parameter int HOLD_CYC = 1000000
) (
  input  logic                inclk0,
  input  logic                rst_n,
  input  logic                ft,
  duty_meas_ctrl_if.slave     bus
);
  localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [CNT_W-1:0]  T_MIN_C   = CNT_W'(T_MIN);
  localparam logic [CNT_W-1:0]  T_MAX_C   = CNT_W'(T_MAX);
  localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TMO_MAX - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

  state_t             state;
  logic [CNT_W-1:0]   hcnt, lcnt, tmo_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]   th_r, t_r;
  logic               valid_r, timeout_r, rerr_r;
  logic               rise, fall;

  logic [CNT_W:0]     t_sum;
  logic               t_sat;
  logic [CNT_W-1:0]   t_val;
  logic               rerr_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  edge_sync u_sync (
    .clk  (inclk0),
    .rst_n(rst_n),
    .d    (ft),
    .rise (rise),
    .fall (fall)
  );

  // Period sum carries one extra bit so an overflow clamps instead of wrapping.
  always_comb begin
    t_sum     = {1'b0, hcnt} + {1'b0, lcnt};
    t_sat     = t_sum[CNT_W];
    t_val     = t_sat ? {CNT_W{1'b1}} : t_sum[CNT_W-1:0];
    rerr_next = t_sat || (t_val < T_MIN_C) || (t_val > T_MAX_C);
  end

  // Result registers load on the closing rise so that tH/T are already
  // stable during the DONE cycle in which valid is high.
  always_ff @(posedge inclk0) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hcnt      <= '0;
      lcnt      <= '0;
      tmo_cnt   <= '0;
      hold_cnt  <= '0;
      th_r      <= '0;
      t_r       <= '0;
      valid_r   <= 1'b0;
      timeout_r <= 1'b0;
      rerr_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        S_IDLE: begin
          tmo_cnt <= '0;
          if (bus.start || bus.auto_en) state <= S_ARM;
        end
        S_ARM, S_HIGH, S_LOW: begin
          // Timeout is tested first so it wins over a simultaneous edge.
          if (tmo_cnt == TMO_LAST) begin
            timeout_r <= 1'b1;
            hold_cnt  <= '0;
            state     <= S_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            case (state)
              S_ARM: begin
                if (rise) begin
                  hcnt  <= CNT_W'(1);
                  state <= S_HIGH;
                end
              end
              S_HIGH: begin
                if (fall) begin
                  lcnt  <= CNT_W'(1);
                  state <= S_LOW;
                end else begin
                  hcnt <= sat_inc(hcnt);
                end
              end
              S_LOW: begin
                if (rise) begin
                  th_r      <= hcnt;
                  t_r       <= t_val;
                  rerr_r    <= rerr_next;
                  timeout_r <= 1'b0;
                  valid_r   <= 1'b1;
                  state     <= S_DONE;
                end else begin
                  lcnt <= sat_inc(lcnt);
                end
              end
              default: ;
            endcase
          end
        end
        S_DONE: begin
          hold_cnt <= '0;
          state    <= S_HOLD;
        end
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            tmo_cnt <= '0;
            state   <= bus.auto_en ? S_ARM : S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.tH        = th_r;
  assign bus.T         = t_r;
  assign bus.valid     = valid_r;
  assign bus.timeout   = timeout_r;
  assign bus.range_err = rerr_r;
  assign bus.busy      = (state != S_IDLE);
endmodule
